relay_driver: RTL

Command-side controller for one electromechanical relay. Accepts on/off commands through a valid/ready handshake, drives the relay `pick` line, and watches the `pulled` contact feedback for completion. Reports completion with a one-cycle `done` pulse, or a sticky `fault` on timeout or unexpected contact loss. Sits between sequencing logic and each `relay` instance, pacing on the shared `tick_ms` strobe.

---
 rtl/relay_pkg.sv | 24 ++
 rtl/relay_driver_sync_2ff.sv | 25 ++
 rtl/relay_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
// Shared definitions for relay_driver: state indices, state count and a
// one-hot encoding helper for the state register.
package relay_pkg;

    localparam int RELAY_DRV_NSTATES = 5;

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        ENGAGING  = 3'd1,
        ON        = 3'd2,
        RELEASING = 3'd3,
        FAULT     = 3'd4
    } relay_drv_state_e;

    typedef logic [RELAY_DRV_NSTATES-1:0] relay_drv_oh_t;

    function automatic relay_drv_oh_t relay_drv_oh(input relay_drv_state_e s);
        relay_drv_oh_t v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/relay_driver_sync_2ff.sv
// Two-flop synchronizer for asynchronous contact feedback; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // metastability filter chain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/relay_driver.sv
// Command-side controller for one relay: drives pick, watches pulled, reports
// done/fault. Define RELAY_DRIVER_SYNC_EN to synchronize pulled through sync_2ff.
module relay_driver
    import relay_pkg::*;
#(
    parameter int T_TIMEOUT = 50,
    parameter int T_HOLD    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic cmd_valid,
    input  logic cmd_on,
    output logic cmd_ready,
    input  logic fault_clr,
    input  logic pulled,
    output logic pick,
    output logic done,
    output logic fault
);

    localparam int T_MAX = (T_TIMEOUT > T_HOLD) ? T_TIMEOUT : T_HOLD;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] CTR_TIMEOUT = CW'(T_TIMEOUT);
    localparam logic [CW-1:0] CTR_HOLD    = CW'(T_HOLD);
    localparam logic [CW-1:0] CTR_ONE     = CW'(32'd1);

    localparam relay_drv_oh_t OH_OFF       = relay_drv_oh(OFF);
    localparam relay_drv_oh_t OH_ENGAGING  = relay_drv_oh(ENGAGING);
    localparam relay_drv_oh_t OH_ON        = relay_drv_oh(ON);
    localparam relay_drv_oh_t OH_RELEASING = relay_drv_oh(RELEASING);
    localparam relay_drv_oh_t OH_FAULT     = relay_drv_oh(FAULT);

    relay_drv_oh_t state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic          pick_q, pick_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic          cmd_ready_s;
    logic          pulled_s;

`ifdef RELAY_DRIVER_SYNC_EN
    sync_2ff u_pulled_sync (
        .clk (clk),
        .rst (rst),
        .d   (pulled),
        .q   (pulled_s)
    );
`else
    assign pulled_s = pulled;
`endif

    // state, ms counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OH_OFF;
            ctr_q   <= '0;
            pick_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            pick_q  <= pick_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // next-state, counter reload and output decode
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        cmd_ready_s = 1'b0;
        if (tick_ms && (ctr_q != '0)) begin
            ctr_d = ctr_q - CTR_ONE;
        end else begin
            ctr_d = ctr_q;
        end
        case (1'b1)
            state_q[OFF]: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid && cmd_on) begin
                    state_d = OH_ENGAGING;
                    ctr_d   = CTR_TIMEOUT;
                end else if (cmd_valid) begin
                    done_d = 1'b1;
                end else begin
                    state_d = OH_OFF;
                end
            end
            state_q[ENGAGING]: begin
                // contact arrival wins over a coincident timeout
                if (pulled_s) begin
                    state_d = OH_ON;
                    ctr_d   = CTR_HOLD;
                    done_d  = 1'b1;
                end else if (tick_ms && (ctr_q == CTR_ONE)) begin
                    state_d = OH_FAULT;
                end else begin
                    state_d = OH_ENGAGING;
                end
            end
            state_q[ON]: begin
                cmd_ready_s = (ctr_q == '0);
                if (!pulled_s) begin
                    state_d = OH_FAULT;
                end else if (cmd_valid && cmd_ready_s && !cmd_on) begin
                    state_d = OH_RELEASING;
                    ctr_d   = CTR_TIMEOUT;
                end else if (cmd_valid && cmd_ready_s) begin
                    done_d = 1'b1;
                end else begin
                    state_d = OH_ON;
                end
            end
            state_q[RELEASING]: begin
                if (!pulled_s) begin
                    state_d = OH_OFF;
                    done_d  = 1'b1;
                end else if (tick_ms && (ctr_q == CTR_ONE)) begin
                    state_d = OH_FAULT;
                end else begin
                    state_d = OH_RELEASING;
                end
            end
            state_q[FAULT]: begin
                if (fault_clr && !pulled_s) begin
                    state_d = OH_OFF;
                end else begin
                    state_d = OH_FAULT;
                end
            end
            default: begin
                state_d = OH_OFF;
                ctr_d   = '0;
            end
        endcase
        pick_d  = state_d[ENGAGING] | state_d[ON];
        fault_d = state_d[FAULT];
    end

    assign cmd_ready = cmd_ready_s;
    assign pick      = pick_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule
